// File: rtl/pc_unit.sv
// Fetch-stage program counter: holds the fetch address and selects the next PC
// from the sequential, branch, jump, register and exception/return sources.
module pc_unit #(
    parameter int unsigned WIDTH    = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180,
    parameter int unsigned IMM_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       npc_sel,
    input  logic             br_taken,
    input  logic [IMM_W-1:0] imm,
    input  logic [25:0]      instr_index,
    input  logic [WIDTH-1:0] reg_target,
    input  logic             exc_req,
    input  logic             eret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] epc,
    output logic             adel
);

    localparam int unsigned EXT_W = WIDTH - IMM_W;

    localparam logic [1:0] SEL_SEQ    = 2'd0;
    localparam logic [1:0] SEL_BRANCH = 2'd1;
    localparam logic [1:0] SEL_JUMP   = 2'd2;
    localparam logic [1:0] SEL_REG    = 2'd3;

    localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_PC);
    localparam logic [WIDTH-1:0] EXC_VAL   = WIDTH'(EXC_PC);

    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] br_target;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] next_pc;

    // Candidate targets, all wrapping modulo 2^WIDTH
    assign pc_plus4    = pc + WIDTH'(4);
    assign imm_ext     = {{EXT_W{imm[IMM_W-1]}}, imm};
    assign br_target   = pc_plus4 + (imm_ext << 2);
    assign jump_target = {pc_plus4[WIDTH-1:28], instr_index, 2'b00};

    // Fetch address is misaligned whenever either low bit is set
    assign adel = |pc[1:0];

    // Normal-flow next-PC select; an untaken branch falls through to pc+4
    always_comb begin
        next_pc = pc_plus4;
        case (npc_sel)
            SEL_SEQ:    next_pc = pc_plus4;
            SEL_BRANCH: next_pc = br_taken ? br_target : pc_plus4;
            SEL_JUMP:   next_pc = jump_target;
            SEL_REG:    next_pc = reg_target;
            default:    next_pc = pc_plus4;
        endcase
    end

    // PC/EPC update: reset, then exception, then return, then stall, then normal flow
    always_ff @(posedge clk) begin
        if (reset) begin
            pc  <= RESET_VAL;
            epc <= '0;
        end else if (exc_req) begin
            pc  <= EXC_VAL;
            epc <= pc;
        end else if (eret) begin
            pc  <= epc;
        end else if (en) begin
            pc  <= next_pc;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed scoreboard bench for pc_unit: the driver queues the expected pc/epc
// after each edge, and a monitor compares pc, pc_plus4, epc and adel mid-cycle.
module tb_pc_unit;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned IMM_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic [1:0]       npc_sel;
    logic             br_taken;
    logic [IMM_W-1:0] imm;
    logic [25:0]      instr_index;
    logic [WIDTH-1:0] reg_target;
    logic             exc_req;
    logic             eret;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] epc;
    logic             adel;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] epc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    pc_unit #(
        .WIDTH    (WIDTH),
        .RESET_PC (32'h0000_3000),
        .EXC_PC   (32'h0000_4180),
        .IMM_W    (IMM_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .npc_sel     (npc_sel),
        .br_taken    (br_taken),
        .imm         (imm),
        .instr_index (instr_index),
        .reg_target  (reg_target),
        .exc_req     (exc_req),
        .eret        (eret),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .epc         (epc),
        .adel        (adel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: outputs are stable mid-cycle, pop one expectation per cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pc", pc, e.pc);
                chk("pc_plus4", pc_plus4, e.pc + 32'd4);
                chk("epc", epc, e.epc);
                chk("adel", {31'd0, adel}, {31'd0, |e.pc[1:0]});
            end
        end
    end

    // Drive one cycle of inputs, then queue the state expected after that edge
    task automatic step(input logic r, input logic e, input logic [1:0] sel,
                        input logic bt, input logic [15:0] im, input logic [25:0] idx,
                        input logic [31:0] rt, input logic ex, input logic er,
                        input logic [31:0] exp_pc, input logic [31:0] exp_epc);
        exp_t x;
        reset       = r;
        en          = e;
        npc_sel     = sel;
        br_taken    = bt;
        imm         = im;
        instr_index = idx;
        reg_target  = rt;
        exc_req     = ex;
        eret        = er;
        @(posedge clk);
        #1;
        x.pc  = exp_pc;
        x.epc = exp_epc;
        sb.push_back(x);
    endtask

    initial begin
        int budget;
        reset = 1'b1; en = 1'b0; npc_sel = 2'd0; br_taken = 1'b0; imm = '0;
        instr_index = '0; reg_target = '0; exc_req = 1'b0; eret = 1'b0;

        //    rst en  sel  bt  imm       idx        reg_target     exc  eret  pc             epc
        step(1, 0, 2'd0, 0, 16'h0000, 26'h0,     32'h0,         0,   0,   32'h0000_3000, 32'h0);
        step(0, 1, 2'd0, 0, 16'h0000, 26'h0,     32'h0,         0,   0,   32'h0000_3004, 32'h0);
        step(0, 1, 2'd0, 0, 16'h0000, 26'h0,     32'h0,         0,   0,   32'h0000_3008, 32'h0);
        step(0, 1, 2'd1, 1, 16'hFFFE, 26'h0,     32'h0,         0,   0,   32'h0000_3004, 32'h0);
        step(0, 1, 2'd0, 0, 16'h0000, 26'h0,     32'h0,         0,   0,   32'h0000_3008, 32'h0);
        step(0, 1, 2'd1, 0, 16'hFFFE, 26'h0,     32'h0,         0,   0,   32'h0000_300C, 32'h0);
        step(0, 1, 2'd2, 0, 16'h0000, 26'h0C40,  32'h0,         0,   0,   32'h0000_3100, 32'h0);
        step(0, 1, 2'd3, 0, 16'h0000, 26'h0,     32'h0000_3202, 0,   0,   32'h0000_3202, 32'h0);
        // stall with a jump selected: pc, epc and adel hold
        for (int i = 0; i < 4; i++)
            step(0, 0, 2'd2, 1, 16'h0004, 26'h0C40, 32'h0,      0,   0,   32'h0000_3202, 32'h0);
        // exception from the misaligned pc, then return to it
        step(0, 0, 2'd3, 0, 16'h0000, 26'h0,     32'h0,         1,   0,   32'h0000_4180, 32'h0000_3202);
        step(0, 1, 2'd0, 0, 16'h0000, 26'h0,     32'h0,         0,   1,   32'h0000_3202, 32'h0000_3202);
        // jump keeps the upper four bits of pc+4
        step(0, 1, 2'd3, 0, 16'h0000, 26'h0,     32'hF000_0000, 0,   0,   32'hF000_0000, 32'h0000_3202);
        step(0, 1, 2'd2, 0, 16'h0000, 26'h0C40,  32'h0,         0,   0,   32'hF000_3100, 32'h0000_3202);
        // wrap-around at the top of the address space
        step(0, 1, 2'd3, 0, 16'h0000, 26'h0,     32'hFFFF_FFFC, 0,   0,   32'hFFFF_FFFC, 32'h0000_3202);
        step(0, 1, 2'd0, 0, 16'h0000, 26'h0,     32'h0,         0,   0,   32'h0000_0000, 32'h0000_3202);
        // forward branch with a positive offset
        step(0, 1, 2'd3, 0, 16'h0000, 26'h0,     32'h0000_3000, 0,   0,   32'h0000_3000, 32'h0000_3202);
        step(0, 1, 2'd1, 1, 16'h0003, 26'h0,     32'h0,         0,   0,   32'h0000_3010, 32'h0000_3202);
        // exception and return while stalled
        step(0, 0, 2'd1, 1, 16'h0003, 26'h0,     32'h0,         1,   0,   32'h0000_4180, 32'h0000_3010);
        step(0, 0, 2'd3, 0, 16'h0000, 26'h0,     32'h1234_5678, 0,   1,   32'h0000_3010, 32'h0000_3010);
        step(0, 1, 2'd0, 0, 16'h0000, 26'h0,     32'h0,         0,   0,   32'h0000_3014, 32'h0000_3010);
        step(0, 1, 2'd0, 0, 16'h0000, 26'h0,     32'h0,         1,   0,   32'h0000_4180, 32'h0000_3014);
        step(0, 1, 2'd0, 0, 16'h0000, 26'h0,     32'h0,         0,   0,   32'h0000_4184, 32'h0000_3014);
        // exception and return together: exception wins
        step(0, 1, 2'd0, 0, 16'h0000, 26'h0,     32'h0,         1,   1,   32'h0000_4180, 32'h0000_4184);
        // return overrides a register jump
        step(0, 1, 2'd3, 0, 16'h0000, 26'h0,     32'h0000_5000, 0,   1,   32'h0000_4184, 32'h0000_4184);
        // reset mid-stall with an exception pending
        step(1, 0, 2'd2, 0, 16'h0000, 26'h0,     32'h0,         1,   0,   32'h0000_3000, 32'h0);

        budget = 0;
        while (sb.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
